// File: rtl/regfile_dump_reader.sv
// Register file dump reader: walks r0..r(NUM_LOW_REGS-1) and optionally r31
// through the regfile debug select, captures each value after a settle delay
// and presents it as {index, data} on a valid/ready stream.
module regfile_dump_reader #(
   parameter int NUM_LOW_REGS  = 16,
   parameter bit INCLUDE_R31   = 1'b1,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_start,
   input  logic        i_abort,
   output logic [4:0]  o_which_reg,
   input  logic [31:0] i_reg_content,
   output logic        o_out_valid,
   input  logic        i_out_ready,
   output logic [31:0] o_out_data,
   output logic [4:0]  o_out_idx,
   output logic        o_out_last,
   output logic        o_busy,
   output logic        o_done
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SEND   = 2'd2
   } state_t;

   localparam logic [4:0] LP_LAST_LOW  = 5'(NUM_LOW_REGS - 1);
   localparam logic [4:0] LP_FINAL_IDX = INCLUDE_R31 ? 5'd31 : LP_LAST_LOW;
   localparam logic [2:0] LP_SETTLE    = 3'(SETTLE_CYCLES);

   state_t      r_state, w_state_nxt;
   logic [2:0]  r_cnt, w_cnt_nxt;
   logic [4:0]  r_which_reg, w_which_reg_nxt;
   logic [31:0] r_out_data, w_out_data_nxt;
   logic [4:0]  r_out_idx, w_out_idx_nxt;
   logic        r_out_last, w_out_last_nxt;
   logic        r_out_valid, w_out_valid_nxt;
   logic        r_done, w_done_nxt;

   logic        w_is_final;
   logic [4:0]  w_next_idx;
   logic        w_start_ok;

   // The select register doubles as the sequence position; after the last
   // low register the walk jumps to r31 (only reachable when INCLUDE_R31=1).
   assign w_is_final = (r_which_reg == LP_FINAL_IDX);
   assign w_next_idx = (r_which_reg == LP_LAST_LOW) ? 5'd31 : r_which_reg + 5'd1;
   // abort beats a simultaneous start in IDLE
   assign w_start_ok = i_start && !i_abort;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples the pre-edge values regardless of statement order.
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode
   always_comb begin
      // NOTE: defaulting every combinational output first keeps paths that
      // assign nothing from inferring latches.
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_start_ok) w_state_nxt = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (i_abort)           w_state_nxt = ST_IDLE;
            else if (r_cnt == '0)  w_state_nxt = ST_SEND;
         end
         ST_SEND: begin
            if (i_abort)           w_state_nxt = ST_IDLE;
            else if (i_out_ready)  w_state_nxt = w_is_final ? ST_IDLE : ST_SETTLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Datapath next values for select, settle counter and the stream word
   always_comb begin
      w_cnt_nxt       = r_cnt;
      w_which_reg_nxt = r_which_reg;
      w_out_data_nxt  = r_out_data;
      w_out_idx_nxt   = r_out_idx;
      w_out_last_nxt  = r_out_last;
      w_out_valid_nxt = r_out_valid;
      w_done_nxt      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_start_ok) begin
               w_which_reg_nxt = 5'd0;
               w_cnt_nxt       = LP_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (i_abort) begin
               w_which_reg_nxt = 5'd0;
               w_out_valid_nxt = 1'b0;
               w_out_last_nxt  = 1'b0;
            end else if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - 3'd1;
            end else begin
               // regfile writes land on negedge, so this posedge capture sees them
               w_out_data_nxt  = i_reg_content;
               w_out_idx_nxt   = r_which_reg;
               w_out_last_nxt  = w_is_final;
               w_out_valid_nxt = 1'b1;
            end
         end
         ST_SEND: begin
            if (i_abort) begin
               w_which_reg_nxt = 5'd0;
               w_out_valid_nxt = 1'b0;
               w_out_last_nxt  = 1'b0;
            end else if (i_out_ready) begin
               w_out_valid_nxt = 1'b0;
               if (w_is_final) begin
                  w_out_last_nxt  = 1'b0;
                  w_which_reg_nxt = 5'd0;
                  w_done_nxt      = 1'b1;
               end else begin
                  w_which_reg_nxt = w_next_idx;
                  w_cnt_nxt       = LP_SETTLE;
               end
            end
         end
         default: begin
            w_which_reg_nxt = 5'd0;
            w_out_valid_nxt = 1'b0;
            w_out_last_nxt  = 1'b0;
         end
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt       <= '0;
         r_which_reg <= '0;
         r_out_data  <= '0;
         r_out_idx   <= '0;
         r_out_last  <= 1'b0;
         r_out_valid <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_cnt       <= w_cnt_nxt;
         r_which_reg <= w_which_reg_nxt;
         r_out_data  <= w_out_data_nxt;
         r_out_idx   <= w_out_idx_nxt;
         r_out_last  <= w_out_last_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_done      <= w_done_nxt;
      end
   end

   assign o_which_reg = r_which_reg;
   assign o_out_valid = r_out_valid;
   assign o_out_data  = r_out_data;
   assign o_out_idx   = r_out_idx;
   assign o_out_last  = r_out_last;
   assign o_done      = r_done;
   assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: a default instance (16 low regs + r31,
// settle 1) and a small instance (4 low regs, no r31, settle 0) share one
// behavioural regfile; sel chooses which instance is exercised.
module tb_regfile_dump_reader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start, abort, ready, sel;
   logic [31:0] regs [32];

   logic [4:0]  a_which, b_which, a_idx, b_idx;
   logic [31:0] a_content, b_content, a_data, b_data;
   logic        a_valid, b_valid, a_last, b_last, a_busy, b_busy, a_done, b_done;

   assign a_content = regs[a_which];
   assign b_content = regs[b_which];

   regfile_dump_reader dut_a (
      .clk(clk), .rst(rst),
      .i_start(start & ~sel), .i_abort(abort & ~sel),
      .o_which_reg(a_which), .i_reg_content(a_content),
      .o_out_valid(a_valid), .i_out_ready(ready),
      .o_out_data(a_data), .o_out_idx(a_idx), .o_out_last(a_last),
      .o_busy(a_busy), .o_done(a_done)
   );

   regfile_dump_reader #(.NUM_LOW_REGS(4), .INCLUDE_R31(1'b0), .SETTLE_CYCLES(0)) dut_b (
      .clk(clk), .rst(rst),
      .i_start(start & sel), .i_abort(abort & sel),
      .o_which_reg(b_which), .i_reg_content(b_content),
      .o_out_valid(b_valid), .i_out_ready(ready),
      .o_out_data(b_data), .o_out_idx(b_idx), .o_out_last(b_last),
      .o_busy(b_busy), .o_done(b_done)
   );

   // Observed signals of the selected instance
   logic [4:0]  s_which, s_idx;
   logic [31:0] s_data;
   logic        s_valid, s_last, s_busy, s_done;
   assign s_which = sel ? b_which : a_which;
   assign s_idx   = sel ? b_idx   : a_idx;
   assign s_data  = sel ? b_data  : a_data;
   assign s_valid = sel ? b_valid : a_valid;
   assign s_last  = sel ? b_last  : a_last;
   assign s_busy  = sel ? b_busy  : a_busy;
   assign s_done  = sel ? b_done  : a_done;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_data"}, s_data, 32'h0);
      check({tag, "_ctrl"}, {18'h0, s_which, s_idx, s_valid, s_last, s_busy, s_done}, 32'h0);
   endtask

   task automatic preload_plan();
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      for (int i = 0; i < 16; i++) regs[i] = 32'h11111111 * 32'(i);
      regs[31] = 32'hDEADBEEF;
   endtask

   task automatic randomize_regs();
      regs[0] = 32'h0;
      for (int i = 1; i < 32; i++) regs[i] = $urandom;
   endtask

   // One dump driven from a negedge; returns on a negedge with the DUT idle.
   // The expected word list is derived from the register-sequence rule and a
   // snapshot of the regfile taken at start.
   task automatic run_dump(input bit rnd, input bit extra, input int abort_idx, input int rst_idx);
      int nlow, settle, total, n, k, done_cnt, last_hs;
      bit with_r31, finished, prev_stall;
      logic [4:0]  exp_idx[$];
      logic [31:0] snap[32];
      logic [31:0] p_data;
      logic [4:0]  p_idx;
      logic        p_last;

      nlow     = sel ? 4 : 16;
      with_r31 = !sel;
      settle   = sel ? 0 : 1;
      exp_idx.delete();
      for (int i = 0; i < nlow; i++) exp_idx.push_back(5'(i));
      if (with_r31) exp_idx.push_back(5'd31);
      total = exp_idx.size();
      for (int i = 0; i < 32; i++) snap[i] = regs[i];

      start = 1'b1; abort = 1'b0; ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      k = 0; n = 0; done_cnt = 0; last_hs = -10; finished = 0; prev_stall = 0;
      p_data = '0; p_idx = '0; p_last = 1'b0;

      while (k < 2000 && !finished) begin
         if (prev_stall) begin
            check("stall_valid", 32'(s_valid), 32'd1);
            check("stall_data", s_data, p_data);
            check("stall_idx", 32'(s_idx), 32'(p_idx));
            check("stall_last", 32'(s_last), 32'(p_last));
         end
         if (s_valid) begin
            if (n < total) begin
               check("word_idx", 32'(s_idx), 32'(exp_idx[n]));
               check("word_data", s_data, snap[exp_idx[n]]);
               check("word_last", 32'(s_last), 32'(n == total - 1));
            end else begin
               check("extra_word", 32'(n), 32'(total - 1));
            end
            check("which_in_send", 32'(s_which), 32'(s_idx));
            if (!rnd) check("word_timing", 32'(k), 32'((settle + 2) * (n + 1) - 1));
         end else if (s_busy && n < total) begin
            check("which_settle", 32'(s_which), 32'(exp_idx[n]));
         end
         check("done", 32'(s_done), 32'(n == total && k == last_hs));
         if (s_done) begin
            done_cnt++;
            if (!rnd) check("dump_length", 32'(k), 32'((settle + 2) * total));
         end
         if (n == total && k == last_hs + 1) begin
            check("idle_after_done", 32'(s_busy), 32'd0);
            finished = 1;
         end

         if (!finished) begin
            if (abort_idx >= 0 && s_busy && !s_valid && s_which == 5'(abort_idx)) begin
               check("abort_words_before", 32'(n), 32'(abort_idx));
               abort = 1'b1;
               @(posedge clk);
               @(negedge clk);
               abort = 1'b0;
               check("abort_valid", 32'(s_valid), 32'd0);
               check("abort_busy", 32'(s_busy), 32'd0);
               check("abort_which", 32'(s_which), 32'd0);
               for (int j = 0; j < 4; j++) begin
                  check("abort_no_done", 32'(s_done | s_busy), 32'd0);
                  @(negedge clk);
               end
               return;
            end
            if (rst_idx >= 0 && s_valid && s_idx == 5'(rst_idx)) begin
               #2 rst = 1'b1;
               #1 check_all_zero("async_rst");
               @(negedge clk);
               rst = 1'b0;
               for (int j = 0; j < 3; j++) begin
                  @(negedge clk);
                  check("rst_no_restart", 32'(s_busy | s_valid), 32'd0);
               end
               return;
            end

            start = extra && s_valid && (n == 3 || n == 10);
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            prev_stall = s_valid && !ready;
            p_data = s_data; p_idx = s_idx; p_last = s_last;
            // Regfile write after this register was captured
            if (s_valid && s_idx != 5'd0) regs[s_idx] = $urandom;
            if (s_valid && ready) begin
               n++;
               last_hs = k + 1;
            end
            @(posedge clk);
            k++;
            @(negedge clk);
         end
      end
      start = 1'b0;
      ready = 1'b1;
      check("dump_finished", 32'(finished), 32'd1);
      check("word_count", 32'(n), 32'(total));
      check("done_count", 32'(done_cnt), 32'd1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      sel = 1'b0; rst = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b1;
      preload_plan();
      #12;
      check_all_zero("reset_a");
      sel = 1'b1;
      #1 check_all_zero("reset_b");
      sel = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Full plan dump, then a back-to-back dump with random backpressure
      run_dump(0, 0, -1, -1);
      preload_plan();
      run_dump(1, 0, -1, -1);
      // Start pulses while busy are ignored
      preload_plan();
      run_dump(0, 1, -1, -1);
      // Abort during SETTLE of idx 5, then a fresh dump
      run_dump(0, 0, 5, -1);
      run_dump(0, 0, -1, -1);

      // abort and start together in IDLE: nothing starts
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      check("abort_start_idle_busy", 32'(s_busy), 32'd0);
      @(negedge clk);
      check("abort_start_idle_valid", 32'(s_valid | s_busy), 32'd0);

      // Reset during SEND of idx 8, then a fresh dump
      preload_plan();
      run_dump(0, 0, -1, 8);
      run_dump(0, 0, -1, -1);

      // Randomized contents and backpressure
      for (int r = 0; r < 4; r++) begin
         randomize_regs();
         run_dump(1, r[0], -1, -1);
      end

      // Small configuration
      sel = 1'b1;
      @(negedge clk);
      randomize_regs();
      run_dump(0, 0, -1, -1);
      randomize_regs();
      run_dump(1, 0, -1, -1);
      run_dump(0, 0, 2, -1);
      run_dump(1, 0, -1, -1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
